// File: rtl/ib_ram_ctrl_pkg.sv
// ib_ram_ctrl_pkg: shared FSM encoding and sizing for the IB-CNU LUT RAM update controller.
package ib_ram_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP, SWAP} state_t;
    localparam int PAGE_NUM = 32;
    localparam int ITER_MAX_DEF = 20;
    localparam int ITER_W = $clog2(ITER_MAX_DEF);
    function automatic int iter_w(input int m);
        return m < 2 ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/ib_page_addr_cnt.sv
// ib_page_addr_cnt: page index counter with increment/clear and a last-page flag.
module ib_page_addr_cnt #(
    parameter int W = 5
) (
    input  logic         write_clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] page_idx,
    output logic         last_page
);
    always_ff @(posedge write_clk or negedge rstn)
        if (!rstn) page_idx <= '0;
        else if (clr) page_idx <= '0;
        else if (inc) page_idx <= page_idx + 1'b1;
    assign last_page = &page_idx;
endmodule

// File: rtl/ib_ram_update_ctrl.sv
// ib_ram_update_ctrl: streams LUT pages into the inactive RAM half, swaps halves and counts iterations.
// Optional IB_RAM_WR_CHECKSUM_EN adds wr_checksum, the XOR of all pages written in the current load.
module ib_ram_update_ctrl
    import ib_ram_ctrl_pkg::*;
#(
    parameter int ENTRY_ADDR    = 6,
    parameter int BANK_NUM      = 2,
    parameter int LUT_PORT_SIZE = 3,
    parameter int ITER_MAX      = 20
) (
    input  logic                                 write_clk,
    input  logic                                 rstn,
    input  logic                                 iter_start,
    input  logic [LUT_PORT_SIZE*BANK_NUM-1:0]    lut_data,
    input  logic                                 lut_valid,
    output logic                                 lut_ready,
    input  logic                                 swap_req,
    output logic [ENTRY_ADDR-1:0]                page_addr_ram,
    output logic [LUT_PORT_SIZE*BANK_NUM-1:0]    ram_write_data_2,
    output logic                                 ib_ram_we,
    output logic                                 read_addr_offset,
    output logic                                 load_done,
    output logic [iter_w(ITER_MAX)-1:0]          iter_cnt,
    output logic                                 decode_end,
    output logic                                 err_overrun
`ifdef IB_RAM_WR_CHECKSUM_EN
    ,output logic [LUT_PORT_SIZE*BANK_NUM-1:0]   wr_checksum
`endif
);
    localparam int PW = ENTRY_ADDR - 1;
    localparam int IW = iter_w(ITER_MAX);
    localparam logic [IW:0] ITER_TOP = (IW+1)'(ITER_MAX);
    state_t state, nxt;
    logic [PW-1:0] page_idx;
    logic last_page, xfer, swap_pend, enter_swap, iter_wrap;
    logic [IW:0] iter_inc;
    assign lut_ready  = state == LOAD;
    assign xfer       = lut_valid && lut_ready;
    assign enter_swap = state == WAIT_SWAP && nxt == SWAP;
    assign iter_inc   = {1'b0, iter_cnt} + 1'b1;
    assign iter_wrap  = iter_inc == ITER_TOP;
    ib_page_addr_cnt #(.W(PW)) u_page_cnt (
        .write_clk (write_clk),
        .rstn      (rstn),
        .inc       (xfer),
        .clr       (state == SWAP),
        .page_idx  (page_idx),
        .last_page (last_page)
    );
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = iter_start ? LOAD : IDLE;
            LOAD:      nxt = xfer && last_page ? WAIT_SWAP : LOAD;
            WAIT_SWAP: nxt = swap_req || swap_pend ? SWAP : WAIT_SWAP;
            default:   nxt = IDLE;
        endcase
    end
    // Swap-side registers update on entry to SWAP so the new half is visible during SWAP.
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            ib_ram_we        <= 1'b0;
            ram_write_data_2 <= '0;
            page_addr_ram    <= '0;
            swap_pend        <= 1'b0;
            load_done        <= 1'b0;
            decode_end       <= 1'b0;
            read_addr_offset <= 1'b0;
            iter_cnt         <= '0;
            err_overrun      <= 1'b0;
        end else begin
            state      <= nxt;
            ib_ram_we  <= xfer;
            swap_pend  <= state == LOAD ? swap_pend || swap_req : state != SWAP && swap_pend;
            load_done  <= state == WAIT_SWAP && nxt == WAIT_SWAP;
            decode_end <= enter_swap && iter_wrap;
            if (xfer) begin
                ram_write_data_2 <= lut_data;
                page_addr_ram    <= {~read_addr_offset, page_idx};
            end
            if (enter_swap) begin
                read_addr_offset <= ~read_addr_offset;
                iter_cnt         <= iter_wrap ? '0 : iter_inc[IW-1:0];
            end
            if (iter_start && state != IDLE) err_overrun <= 1'b1;
        end
    end
`ifdef IB_RAM_WR_CHECKSUM_EN
    always_ff @(posedge write_clk or negedge rstn)
        if (!rstn) wr_checksum <= '0;
        else if (state == IDLE && iter_start) wr_checksum <= '0;
        else if (xfer) wr_checksum <= wr_checksum ^ lut_data;
`endif
endmodule

// File: tb/tb_ib_ram_update_ctrl.sv
// tb_ib_ram_update_ctrl: table-driven load/swap scenarios with a write scoreboard, plus reset corner cases.
module tb_ib_ram_update_ctrl;
    localparam int IM = 3;
    localparam int IW = $clog2(IM);
    logic          write_clk = 1'b0;
    logic          rstn = 1'b0;
    logic          iter_start = 1'b0;
    logic [5:0]    lut_data = '0;
    logic          lut_valid = 1'b0;
    logic          lut_ready;
    logic          swap_req = 1'b0;
    logic [5:0]    page_addr_ram;
    logic [5:0]    ram_write_data_2;
    logic          ib_ram_we;
    logic          read_addr_offset;
    logic          load_done;
    logic [IW-1:0] iter_cnt;
    logic          decode_end;
    logic          err_overrun;
`ifdef IB_RAM_WR_CHECKSUM_EN
    logic [5:0]    wr_checksum;
`endif
    int n_cmp = 0;
    int n_bad = 0;
    logic exp_off = 1'b0;
    logic exp_err = 1'b0;
    logic [11:0] q[$];
    typedef struct {
        logic gap;
        int   swap_at;
        int   ovr_at;
        int   it;
        logic de;
    } vec_t;
    vec_t tbl[5];

    ib_ram_update_ctrl #(.ITER_MAX(IM)) dut (
        .write_clk        (write_clk),
        .rstn             (rstn),
        .iter_start       (iter_start),
        .lut_data         (lut_data),
        .lut_valid        (lut_valid),
        .lut_ready        (lut_ready),
        .swap_req         (swap_req),
        .page_addr_ram    (page_addr_ram),
        .ram_write_data_2 (ram_write_data_2),
        .ib_ram_we        (ib_ram_we),
        .read_addr_offset (read_addr_offset),
        .load_done        (load_done),
        .iter_cnt         (iter_cnt),
        .decode_end       (decode_end),
        .err_overrun      (err_overrun)
`ifdef IB_RAM_WR_CHECKSUM_EN
        ,.wr_checksum     (wr_checksum)
`endif
    );

    always #5 write_clk = ~write_clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic tick();
        logic [11:0] e;
        @(posedge write_clk);
        #1;
        if (ib_ram_we) begin
            chk("write_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_addr", page_addr_ram, e[11:6]);
                chk("wr_data", ram_write_data_2, e[5:0]);
            end
        end
    endtask

    task automatic do_load(input vec_t v);
        int sent = 0;
        int cyc = 0;
        logic val;
        logic [5:0] xs = '0;
        iter_start = 1'b1;
        tick();
        iter_start = 1'b0;
        chk("lut_ready_load", lut_ready, 1);
        while (sent < 32 && cyc < 200) begin
            val = v.gap ? ~cyc[0] : 1'b1;
            lut_valid  = val;
            lut_data   = 6'(sent);
            swap_req   = val && sent == v.swap_at;
            iter_start = val && sent == v.ovr_at;
            if (val) begin
                q.push_back({~exp_off, 5'(sent), 6'(sent)});
                xs ^= 6'(sent);
            end
            if (iter_start) exp_err = 1'b1;
            tick();
            swap_req   = 1'b0;
            iter_start = 1'b0;
            chk("we_pattern", ib_ram_we, val);
            chk("offset_in_load", read_addr_offset, exp_off);
            if (val) sent++;
            cyc++;
        end
        lut_valid = 1'b0;
        chk("pages_sent", sent, 32);
        chk("lut_ready_wait", lut_ready, 0);
        chk("load_done_at_last_wr", load_done, 0);
        if (v.swap_at < 0) begin
            tick();
            chk("load_done_set", load_done, 1);
            tick();
            chk("load_done_held", load_done, 1);
            chk("offset_held_wait", read_addr_offset, exp_off);
            swap_req = 1'b1;
            tick();
            swap_req = 1'b0;
        end else begin
            tick();
        end
        exp_off = ~exp_off;
        chk("offset_swap", read_addr_offset, exp_off);
        chk("iter_cnt_swap", iter_cnt, v.it);
        chk("decode_end_swap", decode_end, v.de);
        chk("load_done_swap", load_done, 0);
        chk("queue_drained", q.size(), 0);
`ifdef IB_RAM_WR_CHECKSUM_EN
        chk("wr_checksum", wr_checksum, xs);
`endif
        tick();
        chk("decode_end_pulse", decode_end, 0);
        chk("lut_ready_idle", lut_ready, 0);
        chk("err_overrun", err_overrun, exp_err);
    endtask

    initial begin
        tbl[0] = '{1'b0, -1, -1, 1, 1'b0};
        tbl[1] = '{1'b1, -1, -1, 2, 1'b0};
        tbl[2] = '{1'b0, 10, -1, 0, 1'b1};
        tbl[3] = '{1'b0, -1,  5, 1, 1'b0};
        tbl[4] = '{1'b1, 20, -1, 2, 1'b0};
        repeat (3) @(posedge write_clk);
        #3 rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("reset_outputs", {lut_ready, page_addr_ram, ram_write_data_2, ib_ram_we,
                read_addr_offset, load_done, iter_cnt, decode_end, err_overrun}, 0);
        end
        foreach (tbl[i]) do_load(tbl[i]);
        chk("offset_before_rst", read_addr_offset, 1);
        iter_start = 1'b1;
        tick();
        iter_start = 1'b0;
        for (int i = 0; i < 17; i++) begin
            lut_valid = 1'b1;
            lut_data  = 6'(i);
            q.push_back({~exp_off, 5'(i), 6'(i)});
            tick();
        end
        lut_data = 6'd17;
        #2;
        chk("we_before_rst", ib_ram_we, 1);
        rstn = 1'b0;
        #1;
        chk("we_async_rst", ib_ram_we, 0);
        lut_valid = 1'b0;
        q.delete();
        exp_off = 1'b0;
        exp_err = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("offset_after_rst", read_addr_offset, 0);
        chk("iter_after_rst", iter_cnt, 0);
        chk("err_after_rst", err_overrun, 0);
        chk("ready_after_rst", lut_ready, 0);
        do_load('{1'b0, -1, -1, 1, 1'b0});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
